awb_stats: RTL and testbench
============================

AWB_STATS -- requirements
Module: awb_stats

Interface
REQ-001 Parameter: LOG2_PIX, default 16, log2 of pixels per frame; legal range 1..20.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pixel_valid_i  input  1  qualifies r_i/g_i/b_i/sof_i/eof_i this cycle.
REQ-005 sof_i  input  1  first pixel of frame; ignored unless pixel_valid_i=1.
REQ-006 eof_i  input  1  last pixel of frame; ignored unless pixel_valid_i=1.
REQ-007 r_i, g_i, b_i  input  8 each  pixel channel values, unsigned.
REQ-008 r_mean_o, g_mean_o, b_mean_o  output  8 each  per-channel frame means, registered; feed the gain block's mean inputs.
REQ-009 valid_o  output  1  one-cycle pulse, means updated; drives the gain block's valid input.
REQ-010 frame_err_o  output  1  one-cycle pulse, malformed frame discarded.
REQ-011 busy_o  output  1  high while state = ACCUM.

Function
REQ-012 The block SHALL implement FSM states IDLE and ACCUM.
REQ-013 Accumulators sum_r/g/b SHALL be 8+LOG2_PIX bits unsigned; pixel counter LOG2_PIX+1 bits; no overflow possible on a legal frame.
REQ-014 IDLE, pixel_valid_i & sof_i & ~eof_i: sums SHALL load current pixel, count <= 1, -> ACCUM.
REQ-015 IDLE, pixel_valid_i without sof_i: pixel SHALL be ignored, no error.
REQ-016 ACCUM, pixel_valid_i & ~sof_i & ~eof_i: sums += pixel, count += 1; if count = 2^LOG2_PIX-1 before the add, SHALL instead pulse frame_err_o, -> IDLE, means unchanged.
REQ-017 ACCUM, pixel_valid_i & eof_i & ~sof_i: if count+1 = 2^LOG2_PIX, means SHALL register floor((sum+pixel)/2^LOG2_PIX) (truncate, no rounding) and valid_o SHALL pulse the next cycle; else frame_err_o pulses, means unchanged; both cases -> IDLE.
REQ-018 Latency: eof pixel sampled at edge k -> means_o and valid_o valid in the cycle after edge k (1 cycle).
REQ-019 ACCUM, pixel_valid_i & sof_i: current frame SHALL be aborted with frame_err_o pulse; new frame starts with this pixel (count <= 1, stays ACCUM).
REQ-020 sof_i & eof_i on same valid pixel (either state): frame_err_o pulse, -> IDLE, means unchanged.
REQ-021 pixel_valid_i=0 cycles SHALL leave sums, count and state unchanged (gaps allowed anywhere).
REQ-022 A valid sof in the cycle immediately after an eof SHALL be accepted (back-to-back frames, no dead cycle).
REQ-023 Means SHALL hold their value between valid_o pulses; valid_o and frame_err_o SHALL never be high together.
REQ-024 busy_o SHALL be combinational from state register only.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, sums 0, count 0, all means 0, valid_o 0, frame_err_o 0, busy_o 0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame with no valid_o or frame_err_o pulse; first valid sof after rst deassert starts a fresh frame.

Verification (LOG2_PIX=2, 4-pixel frames)
REQ-027 Pixels (10,20,30),(20,30,40),(30,40,50),(40,50,61) with sof on 1st, eof on 4th, no gaps -> valid_o pulse 1 cycle after 4th pixel, means 25/35/45.
REQ-028 Same frame with 3-cycle valid gaps between pixels, then immediate second frame all (255,255,255) -> first means 25/35/45, second means 255/255/255, two valid_o pulses.
REQ-029 eof on 3rd pixel -> frame_err_o pulse, no valid_o, means remain previous values.
REQ-030 5 valid pixels without eof after sof -> frame_err_o pulse on 4th-without-eof, state IDLE, 5th pixel ignored.
REQ-031 sof reasserted on 3rd pixel, then 3 more pixels ending eof, all (8,8,8) -> one frame_err_o, then valid_o with means 8/8/8.
REQ-032 rst pulse after 2nd pixel, then a legal frame -> no pulse for aborted frame, valid_o with correct means for the new frame.

Source files
------------

// File: rtl/awb_stats.sv
// rtl/awb_stats.sv - per-frame R/G/B mean statistics for auto white balance
module awb_stats #(
  parameter int LOG2_PIX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_valid_i,
  input  logic       sof_i,
  input  logic       eof_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] r_mean_o,
  output logic [7:0] g_mean_o,
  output logic [7:0] b_mean_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int SW = 8 + LOG2_PIX;
  localparam int CW = LOG2_PIX + 1;

  // Count value held after the next-to-last pixel of a legal frame.
  localparam logic [CW-1:0] LAST_CNT = {1'b0, {LOG2_PIX{1'b1}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sum_r_q, sum_r_d;
  logic [SW-1:0] sum_g_q, sum_g_d;
  logic [SW-1:0] sum_b_q, sum_b_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    r_mean_q, r_mean_d;
  logic [7:0]    g_mean_q, g_mean_d;
  logic [7:0]    b_mean_q, b_mean_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;

  logic [SW-1:0] pix_r, pix_g, pix_b;
  logic [SW-1:0] sum_r_nxt, sum_g_nxt, sum_b_nxt;

  // Zero-extended pixel and the running sums including the current pixel.
  always_comb begin
    pix_r     = {{LOG2_PIX{1'b0}}, r_i};
    pix_g     = {{LOG2_PIX{1'b0}}, g_i};
    pix_b     = {{LOG2_PIX{1'b0}}, b_i};
    sum_r_nxt = sum_r_q + pix_r;
    sum_g_nxt = sum_g_q + pix_g;
    sum_b_nxt = sum_b_q + pix_b;
  end

  // Frame FSM: start/accumulate/close frames, flag malformed ones.
  always_comb begin
    state_d     = state_q;
    sum_r_d     = sum_r_q;
    sum_g_d     = sum_g_q;
    sum_b_d     = sum_b_q;
    count_d     = count_q;
    r_mean_d    = r_mean_q;
    g_mean_d    = g_mean_q;
    b_mean_d    = b_mean_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (pixel_valid_i) begin
      if (sof_i && eof_i) begin
        // A one-pixel frame is never legal.
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else if (sof_i) begin
        // New frame; an unfinished frame in progress is aborted.
        frame_err_d = (state_q == ACCUM);
        sum_r_d     = pix_r;
        sum_g_d     = pix_g;
        sum_b_d     = pix_b;
        count_d     = {{(CW-1){1'b0}}, 1'b1};
        state_d     = ACCUM;
      end else if (state_q == ACCUM) begin
        if (eof_i) begin
          if (count_q == LAST_CNT) begin
            // Division by the power-of-two pixel count is a truncating shift.
            r_mean_d = sum_r_nxt[SW-1:LOG2_PIX];
            g_mean_d = sum_g_nxt[SW-1:LOG2_PIX];
            b_mean_d = sum_b_nxt[SW-1:LOG2_PIX];
            valid_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (count_q == LAST_CNT) begin
          // Frame would exceed its pixel budget without an eof.
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          sum_r_d = sum_r_nxt;
          sum_g_d = sum_g_nxt;
          sum_b_d = sum_b_nxt;
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // State, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_r_q     <= '0;
      sum_g_q     <= '0;
      sum_b_q     <= '0;
      count_q     <= '0;
      r_mean_q    <= '0;
      g_mean_q    <= '0;
      b_mean_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_r_q     <= sum_r_d;
      sum_g_q     <= sum_g_d;
      sum_b_q     <= sum_b_d;
      count_q     <= count_d;
      r_mean_q    <= r_mean_d;
      g_mean_q    <= g_mean_d;
      b_mean_q    <= b_mean_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign r_mean_o    = r_mean_q;
  assign g_mean_o    = g_mean_q;
  assign b_mean_o    = b_mean_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q == ACCUM);

endmodule

// File: tb/tb_awb_stats.sv
// tb/tb_awb_stats.sv - randomized and directed bench for awb_stats with frame-level model
module tb_awb_stats;

  localparam int L    = 2;
  localparam int NPIX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pixel_valid_i, sof_i, eof_i;
  logic [7:0] r_i, g_i, b_i;
  logic [7:0] r_mean_o, g_mean_o, b_mean_o;
  logic       valid_o, frame_err_o, busy_o;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference: the pixels of the frame in progress, and expected outputs.
  bit         m_in;
  int         m_n, m_sr, m_sg, m_sb;
  logic [7:0] e_r, e_g, e_b;
  bit         e_valid, e_err, e_busy;

  awb_stats #(.LOG2_PIX(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_valid_i(pixel_valid_i),
    .sof_i        (sof_i),
    .eof_i        (eof_i),
    .r_i          (r_i),
    .g_i          (g_i),
    .b_i          (b_i),
    .r_mean_o     (r_mean_o),
    .g_mean_o     (g_mean_o),
    .b_mean_o     (b_mean_o),
    .valid_o      (valid_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle, then advance the reference model by the frame rules.
  task automatic step(input bit rs, input bit v, input bit s, input bit e,
                      input int pr, input int pg, input int pb);
    rst = rs; pixel_valid_i = v; sof_i = s; eof_i = e;
    r_i = 8'(pr); g_i = 8'(pg); b_i = 8'(pb);
    @(posedge clk); #1;
    e_valid = 0; e_err = 0;
    if (rs) begin
      m_in = 0; m_n = 0; e_r = 0; e_g = 0; e_b = 0;
    end else if (v) begin
      if (s && e) begin
        e_err = 1; m_in = 0;
      end else if (s) begin
        e_err = m_in; m_in = 1; m_n = 1; m_sr = pr; m_sg = pg; m_sb = pb;
      end else if (m_in) begin
        if (e) begin
          if (m_n + 1 == NPIX) begin
            e_r = 8'((m_sr + pr) / NPIX);
            e_g = 8'((m_sg + pg) / NPIX);
            e_b = 8'((m_sb + pb) / NPIX);
            e_valid = 1;
          end else begin
            e_err = 1;
          end
          m_in = 0;
        end else if (m_n + 1 == NPIX) begin
          e_err = 1; m_in = 0;
        end else begin
          m_n++; m_sr += pr; m_sg += pg; m_sb += pb;
        end
      end
    end
    e_busy = m_in;
  endtask

  function automatic int base_r(input int i); return 10 * (i + 1); endfunction
  function automatic int base_g(input int i); return 10 * (i + 2); endfunction
  function automatic int base_b(input int i); return 10 * (i + 3) + ((i == 3) ? 1 : 0); endfunction

  task automatic test_reset;
    step(1, 1, 1, 0, 99, 99, 99);
    checks++;
    if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !== 27'd0) begin
      failures++;
      $display("FAIL reset got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want all 0",
               valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o);
    end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_basic_frame;
    for (int i = 0; i < NPIX; i++) begin
      step(0, 1, i == 0, i == NPIX - 1, base_r(i), base_g(i), base_b(i));
      checks++;
      if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
          {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
        failures++;
        $display("FAIL basic pix=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                 i, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                 e_valid, e_err, e_busy, e_r, e_g, e_b);
      end
    end
    checks++;
    if ({valid_o, r_mean_o, g_mean_o, b_mean_o} !== {1'b1, 8'd25, 8'd35, 8'd45}) begin
      failures++;
      $display("FAIL basic_means got v=%0b m=%0d/%0d/%0d want v=1 m=25/35/45",
               valid_o, r_mean_o, g_mean_o, b_mean_o);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({valid_o, r_mean_o} !== {1'b0, 8'd25}) begin
      failures++;
      $display("FAIL basic_hold got v=%0b r=%0d want v=0 r=25", valid_o, r_mean_o);
    end
  endtask

  task automatic test_back_to_back;
    int nvalid = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        int gaps = (f == 0 && i < NPIX - 1) ? 3 : 0;
        for (int j = 0; j <= gaps; j++) begin
          if (j == 0) begin
            if (f == 0) step(0, 1, i == 0, i == NPIX - 1, base_r(i), base_g(i), base_b(i));
            else        step(0, 1, i == 0, i == NPIX - 1, 255, 255, 255);
          end else begin
            step(0, 0, 1, 1, 7, 7, 7);
          end
          if (valid_o) nvalid++;
          checks++;
          if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
              {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
            failures++;
            $display("FAIL b2b f=%0d pix=%0d gap=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                     f, i, j, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                     e_valid, e_err, e_busy, e_r, e_g, e_b);
          end
        end
      end
    end
    checks++;
    if (nvalid != 2 || {r_mean_o, g_mean_o, b_mean_o} !== {8'd255, 8'd255, 8'd255}) begin
      failures++;
      $display("FAIL b2b_summary got pulses=%0d m=%0d/%0d/%0d want pulses=2 m=255/255/255",
               nvalid, r_mean_o, g_mean_o, b_mean_o);
    end
  endtask

  task automatic test_short_frame;
    int nerr = 0, nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, i == 0, i == 2, base_r(i), base_g(i), base_b(i));
      nerr += int'(frame_err_o); nvalid += int'(valid_o);
      checks++;
      if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
          {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
        failures++;
        $display("FAIL short pix=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                 i, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                 e_valid, e_err, e_busy, e_r, e_g, e_b);
      end
    end
    checks++;
    if (nerr != 1 || nvalid != 0 || r_mean_o !== 8'd255) begin
      failures++;
      $display("FAIL short_summary got err=%0d valid=%0d r=%0d want err=1 valid=0 r=255",
               nerr, nvalid, r_mean_o);
    end
  endtask

  task automatic test_long_frame;
    int nerr = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i == 0, 0, 40 + i, 50 + i, 60 + i);
      nerr += int'(frame_err_o);
      checks++;
      if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
          {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
        failures++;
        $display("FAIL long pix=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                 i, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                 e_valid, e_err, e_busy, e_r, e_g, e_b);
      end
      if (i == 3) begin
        checks++;
        if (frame_err_o !== 1'b1 || busy_o !== 1'b0) begin
          failures++;
          $display("FAIL long_4th got err=%0b busy=%0b want err=1 busy=0", frame_err_o, busy_o);
        end
      end
    end
    checks++;
    if (nerr != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL long_summary got err=%0d busy=%0b want err=1 busy=0", nerr, busy_o);
    end
  endtask

  task automatic test_sof_restart;
    int nerr = 0, nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, i == 0 || i == 2, i == 5, 8, 8, 8);
      nerr += int'(frame_err_o); nvalid += int'(valid_o);
      checks++;
      if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
          {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
        failures++;
        $display("FAIL restart pix=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                 i, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                 e_valid, e_err, e_busy, e_r, e_g, e_b);
      end
    end
    checks++;
    if (nerr != 1 || nvalid != 1 || {r_mean_o, g_mean_o, b_mean_o} !== {8'd8, 8'd8, 8'd8}) begin
      failures++;
      $display("FAIL restart_summary got err=%0d valid=%0d m=%0d/%0d/%0d want err=1 valid=1 m=8/8/8",
               nerr, nvalid, r_mean_o, g_mean_o, b_mean_o);
    end
  endtask

  task automatic test_reset_midframe;
    int nerr = 0, nvalid = 0;
    for (int t = 0; t < 7; t++) begin
      if (t < 2)       step(0, 1, t == 0, 0, 200, 200, 200);
      else if (t == 2) step(1, 0, 0, 0, 0, 0, 0);
      else             step(0, 1, t == 3, t == 6, base_r(t - 3), base_g(t - 3), base_b(t - 3));
      nerr += int'(frame_err_o); nvalid += int'(valid_o);
      checks++;
      if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
          {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
        failures++;
        $display("FAIL rst_mid t=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                 t, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                 e_valid, e_err, e_busy, e_r, e_g, e_b);
      end
    end
    checks++;
    if (nerr != 0 || nvalid != 1 || {r_mean_o, g_mean_o, b_mean_o} !== {8'd25, 8'd35, 8'd45}) begin
      failures++;
      $display("FAIL rst_mid_summary got err=%0d valid=%0d m=%0d/%0d/%0d want err=0 valid=1 m=25/35/45",
               nerr, nvalid, r_mean_o, g_mean_o, b_mean_o);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 600; t++) begin
      bit rs = ($urandom_range(0, 79) == 0);
      bit v  = ($urandom_range(0, 9) < 7);
      bit s  = ($urandom_range(0, 99) < (m_in ? 8 : 35));
      bit e  = ($urandom_range(0, 99) < ((m_in && m_n == NPIX - 1) ? 75 : 10));
      step(rs, v, s, e, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      checks++;
      if ({valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o} !==
          {e_valid, e_err, e_busy, e_r, e_g, e_b}) begin
        failures++;
        $display("FAIL random t=%0d got v=%0b e=%0b busy=%0b m=%0d/%0d/%0d want v=%0b e=%0b busy=%0b m=%0d/%0d/%0d",
                 t, valid_o, frame_err_o, busy_o, r_mean_o, g_mean_o, b_mean_o,
                 e_valid, e_err, e_busy, e_r, e_g, e_b);
      end
      checks++;
      if (valid_o && frame_err_o) begin
        failures++;
        $display("FAIL random_exclusive t=%0d got v=1 e=1 want not both", t);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pixel_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    r_i = '0; g_i = '0; b_i = '0;
    m_in = 0; m_n = 0; m_sr = 0; m_sg = 0; m_sb = 0;
    e_r = 0; e_g = 0; e_b = 0; e_valid = 0; e_err = 0; e_busy = 0;
    @(posedge clk); #1;
    test_reset;
    test_basic_frame;
    test_back_to_back;
    test_short_frame;
    test_long_frame;
    test_sof_restart;
    test_reset_midframe;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
